// File: rtl/fetch_seq_pkg.sv
// Shared widths, FSM encodings and types for the instruction-fetch sequencer.
// The optional misaligned-redirect trap is enabled with FETCH_MISALIGN_TRAP_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef FETCH_ST_IDLE
`define FETCH_ST_IDLE  3'd0
`define FETCH_ST_REQ   3'd1
`define FETCH_ST_WAIT  3'd2
`define FETCH_ST_HOLD  3'd3
`define FETCH_ST_FAULT 3'd4
`endif

package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = `FETCH_ST_IDLE,
    ST_REQ   = `FETCH_ST_REQ,
    ST_WAIT  = `FETCH_ST_WAIT,
    ST_HOLD  = `FETCH_ST_HOLD,
    ST_FAULT = `FETCH_ST_FAULT
  } fetch_st_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: reset load, sequential +4 step and redirect load.
// With FETCH_MISALIGN_TRAP_EN the raw target is kept and flagged; otherwise it is word-aligned.
module fetch_pc_reg
  import fetch_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH = `DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic                  incr,
  output logic [DATA_WIDTH-1:0] pc_q,
  output logic                  misaligned
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] load_val;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign load_val   = target;
  assign misaligned = |target[1:0];
`else
  assign load_val   = target & ALIGN_MASK;
  assign misaligned = 1'b0;
`endif

  // Redirect outranks the sequential step; the +4 wraps naturally at the top of the address space.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_val;
    end else if (incr) begin
      pc_q <= pc_q + DATA_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: one outstanding imem request, single-entry instruction buffer, squashing redirects.
// Optional misaligned-redirect trap state is compiled in with FETCH_MISALIGN_TRAP_EN.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH = `DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect_valid,
  input  logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  input  logic                    imem_rsp_valid,
  input  logic [`INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                    if_valid,
  input  logic                    if_ready,
  output logic [DATA_WIDTH-1:0]   if_pc,
  output logic [`INSTR_WIDTH-1:0] if_instr,
  output logic                    fetch_fault
);

  fetch_st_e               st_q, st_d;
  logic [`INSTR_WIDTH-1:0] instr_q;
  logic                    drop_q, drop_d;
  logic                    instr_load;
  logic                    pc_load, pc_incr;
  logic                    misaligned, fault_take;
  logic [DATA_WIDTH-1:0]   pc_q;

  fetch_pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .target     (redirect_pc),
    .incr       (pc_incr),
    .pc_q       (pc_q),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      instr_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      drop_q <= drop_d;
      if (instr_load) begin
        instr_q <= imem_rsp_data;
      end
    end
  end

  // Next state and outputs; only the two valids look at redirect_valid combinationally.
  always_comb begin
    st_d           = st_q;
    drop_d         = drop_q;
    instr_load     = 1'b0;
    pc_load        = 1'b0;
    pc_incr        = 1'b0;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    if_valid       = 1'b0;
    if_pc          = '0;
    if_instr       = '0;
    fault_take     = redirect_valid && misaligned && (st_q != ST_FAULT);

    case (st_q)
      ST_IDLE: begin
        st_d = ST_REQ;
        if (fault_take) begin
          pc_load = 1'b1;
          st_d    = ST_FAULT;
        end
      end

      ST_REQ: begin
        imem_req_valid = !redirect_valid;
        imem_addr      = pc_q;
        if (fault_take) begin
          pc_load = 1'b1;
          st_d    = ST_FAULT;
        end else if (redirect_valid) begin
          pc_load = 1'b1;
        end else if (imem_req_ready) begin
          st_d = ST_WAIT;
        end
      end

      // A redirect before the response arrives marks that response for discard.
      ST_WAIT: begin
        if (fault_take) begin
          pc_load = 1'b1;
          st_d    = ST_FAULT;
        end else if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            pc_load = redirect_valid;
            drop_d  = 1'b0;
            st_d    = ST_REQ;
          end else begin
            instr_load = 1'b1;
            st_d       = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_load = 1'b1;
          drop_d  = 1'b1;
        end
      end

      ST_HOLD: begin
        if_valid = !redirect_valid;
        if_pc    = pc_q;
        if_instr = instr_q;
        if (fault_take) begin
          pc_load = 1'b1;
          st_d    = ST_FAULT;
        end else if (redirect_valid) begin
          pc_load = 1'b1;
          st_d    = ST_REQ;
        end else if (if_ready) begin
          pc_incr = 1'b1;
          st_d    = ST_REQ;
        end
      end

      ST_FAULT: begin
        if_pc = pc_q;
      end

      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (st_q == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the architectural PC register and drives the next-PC datapath's results into an instruction-memory request/response interface. It issues one fetch at a time, buffers the returned instruction, hands it to decode with a valid/ready handshake, and applies control-flow redirects from execute (branch/JAL/JALR targets). Any fetch in flight when a redirect arrives is squashed.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): PC/address width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `redirect_valid`  in  1: execute resolved a taken branch, JAL or JALR this cycle.
- `redirect_pc`  in  DATA_WIDTH: target from the next-PC logic.
- `imem_req_valid`  out  1: fetch request.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_addr`  out  DATA_WIDTH: fetch address.
- `imem_rsp_valid`  in  1: read data valid.
- `imem_rsp_data`  in  32: instruction word.
- `if_valid`  out  1: instruction available to decode.
- `if_ready`  in  1: decode consumes it.
- `if_pc`  out  DATA_WIDTH: PC of the presented instruction.
- `if_instr`  out  32: presented instruction.
- `fetch_fault`  out  1: misaligned redirect trap. Tied 0 when the feature is compiled out.

## Operation
- State register `st_q` has states IDLE, REQ, WAIT, HOLD and FAULT. Other registers: `pc_q`, `instr_q`, `drop_q`.
- **Reset (`rst_n`=0 at an edge):** `st_q`=IDLE, `pc_q`=RESET_PC, `instr_q`=0, `drop_q`=0, `fetch_fault`=0.
  - In IDLE every output is 0, including `imem_addr`, `if_pc` and `if_instr`.
- **IDLE:** goes to REQ unconditionally on the next edge.
- **REQ:**
  - `imem_req_valid` = !`redirect_valid`; `imem_addr` = `pc_q`.
  - Redirect: `pc_q` <= `redirect_pc`, stay in REQ. No request is issued that cycle.
  - Else if `imem_req_ready`: go to WAIT.
- **WAIT:** `imem_req_valid`=0.
  - Redirect without `imem_rsp_valid`: `pc_q` <= `redirect_pc`, `drop_q` <= 1.
  - On `imem_rsp_valid`, if `drop_q` or `redirect_valid` is set: discard the data, clear `drop_q`, go to REQ. If `redirect_valid` is set, also load `redirect_pc`.
  - On `imem_rsp_valid` otherwise: `instr_q` <= `imem_rsp_data`, go to HOLD.
- **HOLD:**
  - `if_valid` = !`redirect_valid`; `if_pc` = `pc_q`; `if_instr` = `instr_q`.
  - Redirect has priority over `if_ready`: `pc_q` <= `redirect_pc`, go to REQ.
  - Else if `if_ready`: `pc_q` <= `pc_q` + 4, go to REQ.
  - Else hold every output stable.
- **PC arithmetic:** `pc_q` + 4 wraps modulo 2^DATA_WIDTH, so 0xFFFF_FFFC becomes 0x0.
- **Responses outside WAIT:** ignored. Memory must never send one.
- **Reset mid-operation:** reset takes priority over all events. Any outstanding request is abandoned. Memory must drop it on reset.

## Timing
- Exactly one request is outstanding at a time.
- Zero-wait memory (ready in REQ, response the next cycle) gives REQ, then WAIT, then HOLD.
  - `if_valid` rises 2 cycles after the request handshake.
  - Throughput is 1 instruction per 3 cycles when `if_ready`=1.
- Redirect-to-request latency is 1 cycle from REQ or HOLD.
- From WAIT, the request for the redirect target is issued in the cycle after the squashed response.
- The combinational paths are `redirect_valid` to `imem_req_valid` and `redirect_valid` to `if_valid`. All other outputs come from registers.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]` != 0, in any state, loads `pc_q` with the target and sets `fetch_fault`=1.
  - The block then enters FAULT. In FAULT, `imem_req_valid`=0, `if_valid`=0 and `if_pc`=`pc_q`, the faulting target.
  - Only reset exits FAULT.
- `FETCH_MISALIGN_TRAP_EN` not defined:
  - `redirect_pc[1:0]` is forced to 00 on load.
  - FAULT is unreachable and `fetch_fault`=0.

## Structure
- State encodings go in `defines.vh` as `FETCH_ST_IDLE`..`FETCH_ST_FAULT` (3-bit), alongside `` `DATA_WIDTH `` and a new `` `INSTR_WIDTH `` (32).
- One sub-module, `fetch_pc_reg`: `pc_q` with reset load, +4 increment, redirect load and the alignment masking/check.
- The FSM and instruction buffer stay in `fetch_seq`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0. After release, IDLE lasts one cycle, then `imem_req_valid`=1 with `imem_addr`=0x0.
- **Sequential fetch:** zero-wait memory returns 0x0000_0013 → `if_pc` = 0x0, 0x4, 0x8, with `if_valid` every 3rd cycle. With `RESET_PC`=0xFFFF_FFFC, the second fetch is at 0x0.
- **Backpressure:** `if_ready`=0 for 5 cycles in HOLD → `if_valid`=1 and `if_pc`/`if_instr` stable, with no `imem_req_valid`. Then `if_ready`=1 → next request at +4.
- **Redirect in WAIT:** redirect to 0x100 while 0x4 is outstanding, response 0xDEAD_BEEF → response discarded and `if_valid` never shows it. Next `imem_addr`=0x100, then `if_pc`=0x100.
- **Redirect vs consume in HOLD:** `if_ready`=1 and redirect 0x200 in the same cycle → `if_valid`=0 that cycle and the next request is 0x200, not `pc_q`+4.
- **Misalign:** redirect 0x102 with the macro defined → `fetch_fault`=1, `if_pc`=0x102, no further requests until reset. Without the macro → next `imem_addr`=0x100.
